// File: rtl/apb_mem_pkg.sv
// Shared types and address decode for the parametrised APB4 memory slave.
package apb_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        ERR
    } state_t;

    localparam int WAIT_W = 4;

    typedef struct packed {
        logic        err;
        logic [63:0] index;
    } decode_t;

    // Subtraction is one bit wider than the address so an address below the
    // base shows up as a borrow instead of wrapping into a valid index.
    function automatic decode_t addr_decode(
        input logic [63:0] paddr,
        input logic [63:0] base_addr,
        input int          depth,
        input int          data_w
    );
        decode_t     r;
        logic [64:0] diff;
        logic [63:0] mask;
        int          sh;
        sh      = $clog2(data_w / 8);
        mask    = (64'd1 << sh) - 64'd1;
        diff    = {1'b0, paddr} - {1'b0, base_addr};
        r.index = diff[63:0] >> sh;
        r.err   = diff[64] | (|(paddr & mask)) | (r.index >= 64'(depth));
        return r;
    endfunction

endpackage

// File: rtl/apb_mem_array.sv
// Word storage with a byte-enabled synchronous write port and an asynchronous read port.
module apb_mem_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [IDX_W-1:0]      waddr_i,
    input  logic [DATA_W-1:0]     wdata_i,
    input  logic [DATA_W/8-1:0]   wstrb_i,
    input  logic [IDX_W-1:0]      raddr_i,
    output logic [DATA_W-1:0]     rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < DATA_W / 8; b++) begin
                if (wstrb_i[b]) begin
                    mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/apb_mem_slave.sv
// APB4 memory slave: setup/access FSM with programmable wait states, byte
// strobes and pslverr on decode or protocol errors.
module apb_mem_slave
    import apb_mem_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter int                DEPTH       = 256,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int                WAIT_STATES = 0
) (
    input  logic                  pclk,
    input  logic                  preset,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_W-1:0]     paddr,
    input  logic [DATA_W-1:0]     pwdata,
    input  logic [DATA_W/8-1:0]   pstrb,
    output logic                  pready,
    output logic [DATA_W-1:0]     prdata,
    output logic                  pslverr
);

    localparam int IDX_W = $clog2(DEPTH);

    state_t            state_q;
    logic [WAIT_W-1:0] cnt_q;
    logic              err_q;
    logic [IDX_W-1:0]  idx_q;
    logic [DATA_W-1:0] prdata_q;
    logic [DATA_W-1:0] prdata_d;
    logic [DATA_W-1:0] rd_word;
    decode_t           dec;
    logic              cnt_zero;
    logic              done;
    logic              we;

    assign dec      = addr_decode(64'(paddr), 64'(BASE_ADDR), DEPTH, DATA_W);
    assign cnt_zero = (cnt_q == '0);
    assign done     = (state_q == ACCESS) && psel && penable && cnt_zero;
    // A reset arriving on the completion edge must not commit the write.
    assign we       = done && pwrite && !err_q && !preset;
    assign prdata_d = (!pwrite && !dec.err) ? rd_word : '0;

    assign pready  = (state_q == ERR) || ((state_q == ACCESS) && cnt_zero);
    assign pslverr = (state_q == ERR) || ((state_q == ACCESS) && cnt_zero && err_q);
    assign prdata  = prdata_q;

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            idx_q    <= '0;
            prdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (psel && !penable) begin
                        state_q  <= ACCESS;
                        cnt_q    <= WAIT_W'(WAIT_STATES);
                        err_q    <= dec.err;
                        idx_q    <= dec.index[IDX_W-1:0];
                        prdata_q <= prdata_d;
                    end else if (psel && penable) begin
                        state_q  <= ERR;
                        prdata_q <= '0;
                    end
                end
                ACCESS: begin
                    if (!psel) begin
                        state_q <= IDLE;
                    end else if (penable) begin
                        if (cnt_zero) begin
                            state_q <= IDLE;
                        end else begin
                            cnt_q <= cnt_q - WAIT_W'(1);
                        end
                    end
                end
                ERR:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    apb_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk_i   (pclk),
        .we_i    (we),
        .waddr_i (idx_q),
        .wdata_i (pwdata),
        .wstrb_i (pstrb),
        .raddr_i (dec.index[IDX_W-1:0]),
        .rdata_o (rd_word)
    );

endmodule

// File: tb/tb_apb_mem_slave.sv
// Scoreboard bench for apb_mem_slave: three instances with different wait/base settings.
module tb_apb_mem_slave;

    logic        pclk = 1'b0;
    logic        preset = 1'b1;
    logic [2:0]  psel = 3'b111;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [31:0] paddr = '0;
    logic [31:0] pwdata = '0;
    logic [3:0]  pstrb = '0;
    logic [2:0]  pready;
    logic [2:0]  pslverr;
    logic [31:0] prdata [3];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          waits;
        string       name;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model [int];

    always #5 pclk = ~pclk;

    apb_mem_slave #(.ADDR_W(32), .DATA_W(32), .DEPTH(256), .BASE_ADDR(32'h0), .WAIT_STATES(0)) u0 (
        .pclk(pclk), .preset(preset), .psel(psel[0]), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
        .pready(pready[0]), .prdata(prdata[0]), .pslverr(pslverr[0]));

    apb_mem_slave #(.ADDR_W(32), .DATA_W(32), .DEPTH(256), .BASE_ADDR(32'h0), .WAIT_STATES(3)) u1 (
        .pclk(pclk), .preset(preset), .psel(psel[1]), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
        .pready(pready[1]), .prdata(prdata[1]), .pslverr(pslverr[1]));

    apb_mem_slave #(.ADDR_W(32), .DATA_W(32), .DEPTH(256), .BASE_ADDR(32'h1000), .WAIT_STATES(2)) u2 (
        .pclk(pclk), .preset(preset), .psel(psel[2]), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
        .pready(pready[2]), .prdata(prdata[2]), .pslverr(pslverr[2]));

    function automatic int waits_of(input int d);
        case (d)
            0:       return 0;
            1:       return 3;
            default: return 2;
        endcase
    endfunction

    function automatic logic [31:0] base_of(input int d);
        return (d == 2) ? 32'h1000 : 32'h0;
    endfunction

    function automatic logic exp_err(input int d, input logic [31:0] a);
        if (a < base_of(d)) return 1'b1;
        if (a[1:0] != 2'b00) return 1'b1;
        return ((a - base_of(d)) >> 2) >= 32'd256;
    endfunction

    function automatic int key_of(input int d, input logic [31:0] a);
        return d * 1048576 + int'(a[19:0]);
    endfunction

    // Full transfer; starts immediately so consecutive calls run back-to-back.
    task automatic apb_xfer(input int d, input logic wr, input logic [31:0] a,
                            input logic [31:0] wd, input logic [3:0] st, input string nm);
        exp_t        e;
        exp_t        got;
        logic [31:0] word;
        int          k;
        int          w;
        e.err   = exp_err(d, a);
        e.waits = waits_of(d);
        e.name  = nm;
        e.data  = 32'h0;
        k = key_of(d, a);
        if (!e.err) begin
            word = model.exists(k) ? model[k] : 32'h0;
            if (wr) begin
                for (int b = 0; b < 4; b++) begin
                    if (st[b]) word[b*8 +: 8] = wd[b*8 +: 8];
                end
                model[k] = word;
            end else begin
                e.data = word;
            end
        end
        sb.push_back(e);
        psel[d] = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd; pstrb = st;
        @(posedge pclk); #1;
        penable = 1'b1;
        w = 0;
        while (pready[d] !== 1'b1 && w < 40) begin
            @(posedge pclk); #1;
            w++;
        end
        got = sb.pop_front();
        checks++;
        if (w != got.waits) begin
            errors++;
            $display("FAIL %s wait cycles: got %0d expected %0d", got.name, w, got.waits);
        end
        checks++;
        if (prdata[d] !== got.data) begin
            errors++;
            $display("FAIL %s prdata: got %h expected %h", got.name, prdata[d], got.data);
        end
        checks++;
        if (pslverr[d] !== got.err) begin
            errors++;
            $display("FAIL %s pslverr: got %b expected %b", got.name, pslverr[d], got.err);
        end
        @(posedge pclk); #1;
        psel[d] = 1'b0; penable = 1'b0;
    endtask

    task automatic test_reset();
        preset = 1'b1; psel = 3'b111; penable = 1'b0;
        repeat (2) begin
            @(posedge pclk); #1;
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (pready[d] !== 1'b0 || pslverr[d] !== 1'b0 || prdata[d] !== 32'h0) begin
                    errors++;
                    $display("FAIL reset dut%0d: pready=%b pslverr=%b prdata=%h expected 0/0/0",
                             d, pready[d], pslverr[d], prdata[d]);
                end
            end
        end
        preset = 1'b0; psel = 3'b000;
        @(posedge pclk); #1;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (pready[d] !== 1'b0 || pslverr[d] !== 1'b0) begin
                errors++;
                $display("FAIL post_reset_idle dut%0d: pready=%b pslverr=%b expected 0/0",
                         d, pready[d], pslverr[d]);
            end
        end
    endtask

    task automatic test_basic();
        apb_xfer(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, "basic_wr");
        apb_xfer(0, 1'b0, 32'h10, 32'h0, 4'hF, "basic_rd");
    endtask

    task automatic test_wait_states();
        apb_xfer(1, 1'b1, 32'h10, 32'h5A5AA5A5, 4'hF, "wait_wr");
        apb_xfer(1, 1'b0, 32'h10, 32'h0, 4'h0, "wait_rd");
    endtask

    task automatic test_strobes();
        apb_xfer(0, 1'b1, 32'h20, 32'h11223344, 4'hF, "strb_full");
        apb_xfer(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'h5, "strb_0101");
        apb_xfer(0, 1'b0, 32'h20, 32'h0, 4'h0, "strb_rd");
        apb_xfer(0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, "strb_none");
        apb_xfer(0, 1'b0, 32'h20, 32'h0, 4'hF, "strb_none_rd");
    endtask

    task automatic test_decode();
        apb_xfer(2, 1'b1, 32'h13FC, 32'h0BADCAFE, 4'hF, "dec_last_wr");
        apb_xfer(2, 1'b1, 32'h1000, 32'h01020304, 4'hF, "dec_first_wr");
        apb_xfer(2, 1'b0, 32'h0FFC, 32'h0, 4'h0, "dec_below_rd");
        apb_xfer(2, 1'b1, 32'h1400, 32'hEEEEEEEE, 4'hF, "dec_above_wr");
        apb_xfer(2, 1'b1, 32'h1002, 32'hDDDDDDDD, 4'hF, "dec_misal_wr");
        apb_xfer(2, 1'b0, 32'h13FC, 32'h0, 4'h0, "dec_last_rd");
        apb_xfer(2, 1'b0, 32'h1000, 32'h0, 4'h0, "dec_first_rd");
    endtask

    task automatic test_protocol_err();
        psel[0] = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 32'h10;
        @(posedge pclk); #1;
        checks++;
        if (pready[0] !== 1'b1 || pslverr[0] !== 1'b1 || prdata[0] !== 32'h0) begin
            errors++;
            $display("FAIL proto_err: pready=%b pslverr=%b prdata=%h expected 1/1/0",
                     pready[0], pslverr[0], prdata[0]);
        end
        psel[0] = 1'b0; penable = 1'b0;
        @(posedge pclk); #1;
        checks++;
        if (pready[0] !== 1'b0 || pslverr[0] !== 1'b0) begin
            errors++;
            $display("FAIL proto_err_release: pready=%b pslverr=%b expected 0/0",
                     pready[0], pslverr[0]);
        end
    endtask

    task automatic test_abort();
        apb_xfer(2, 1'b1, 32'h1010, 32'hCAFEF00D, 4'hF, "abort_pre_wr");
        psel[2] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h1010;
        pwdata = 32'h12345678; pstrb = 4'hF;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #1;
        checks++;
        if (pready[2] !== 1'b0) begin
            errors++;
            $display("FAIL abort_wait_pready: got %b expected 0", pready[2]);
        end
        psel[2] = 1'b0; penable = 1'b0;
        @(posedge pclk); #1;
        apb_xfer(2, 1'b0, 32'h1010, 32'h0, 4'h0, "abort_post_rd");
    endtask

    task automatic test_reset_mid_transfer();
        apb_xfer(0, 1'b1, 32'h40, 32'h600DF00D, 4'hF, "rst_pre_wr");
        psel[0] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h40;
        pwdata = 32'hBAD0BAD0; pstrb = 4'hF;
        @(posedge pclk); #1;
        penable = 1'b1; preset = 1'b1;
        @(posedge pclk); #1;
        checks++;
        if (pready[0] !== 1'b0 || pslverr[0] !== 1'b0 || prdata[0] !== 32'h0) begin
            errors++;
            $display("FAIL rst_mid: pready=%b pslverr=%b prdata=%h expected 0/0/0",
                     pready[0], pslverr[0], prdata[0]);
        end
        preset = 1'b0; psel[0] = 1'b0; penable = 1'b0;
        @(posedge pclk); #1;
        apb_xfer(0, 1'b0, 32'h40, 32'h0, 4'h0, "rst_post_rd");
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        apb_xfer(0, 1'b1, 32'h30, 32'h0F0F0F0F, 4'hF, "b2b_wr");
        apb_xfer(0, 1'b0, 32'h30, 32'h0, 4'h0, "b2b_raw");
        for (int i = 0; i < 4; i++) begin
            d = $urandom;
            apb_xfer(0, 1'b1, 32'h100 + 32'(i * 4), d, 4'hF, "b2b_loop_wr");
        end
        for (int i = 0; i < 4; i++) begin
            apb_xfer(0, 1'b0, 32'h100 + 32'(i * 4), 32'h0, 4'h0, "b2b_loop_rd");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_wait_states();
        test_strobes();
        test_decode();
        test_protocol_err();
        test_abort();
        test_reset_mid_transfer();
        test_back_to_back();
        repeat (2) @(posedge pclk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
